// File: rtl/gate_freq_meter_if.sv
// Measurement-window and sensor inputs plus latched result outputs of gate_freq_meter.
// master drives gate/sig_in and reads results; slave is the meter itself.
interface gate_freq_meter_if #(
   parameter int unsigned CNT_W = 16
);
   logic             gate;
   logic             sig_in;
   logic [CNT_W-1:0] freq_cnt;
   logic             valid;
   logic             overflow;
   logic             busy;

   modport master (
      output gate,
      output sig_in,
      input  freq_cnt,
      input  valid,
      input  overflow,
      input  busy
   );

   modport slave (
      input  gate,
      input  sig_in,
      output freq_cnt,
      output valid,
      output overflow,
      output busy
   );
endinterface

// File: rtl/gate_freq_meter.sv
// Gated edge counter: counts synchronised sig_in rising edges while the sampled
// gate is high and latches the count with a one-cycle valid at gate fall.
module gate_freq_meter #(
   parameter int unsigned CNT_W  = 16,
   parameter bit          SAT_EN = 1'b1
) (
   input logic             clk_in,
   input logic             rst,
   gate_freq_meter_if.slave fm
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic             sig_s1;
   logic             sig_s2;
   logic             sig_d;
   logic             gate_s1;
   logic             gate_s2;
   logic             gate_d;

   logic [1:0]       prime;
   logic             armed;

   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] counter_nxt;
   logic             ovf_int;
   logic             ovf_int_nxt;
   logic             latch_now;

   logic [CNT_W-1:0] freq_cnt_q;
   logic             valid_q;
   logic             overflow_q;

   logic             sig_rise;
   logic             gate_rise;
   logic             gate_fall;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sig_s1  <= 1'b0;
         sig_s2  <= 1'b0;
         sig_d   <= 1'b0;
         gate_s1 <= 1'b0;
         gate_s2 <= 1'b0;
         gate_d  <= 1'b0;
      end else begin
         sig_s1  <= fm.sig_in;
         sig_s2  <= sig_s1;
         sig_d   <= sig_s2;
         gate_s1 <= fm.gate;
         gate_s2 <= gate_s1;
         gate_d  <= gate_s2;
      end
   end

   assign sig_rise  = sig_s2 & ~sig_d;
   assign gate_rise = gate_s2 & ~gate_d;
   assign gate_fall = ~gate_s2 & gate_d;

   // The synchronisers clear to 0, so a gate already high at reset release looks
   // like a rising edge; windows are only armed once gate_s2 is genuinely seen low.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         prime <= '0;
         armed <= 1'b0;
      end else begin
         if (prime != 2'd2) begin
            prime <= prime + 2'd1;
         end
         if ((prime == 2'd2) && !gate_s2) begin
            armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state   <= IDLE;
         counter <= '0;
         ovf_int <= 1'b0;
      end else begin
         state   <= state_nxt;
         counter <= counter_nxt;
         ovf_int <= ovf_int_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      ovf_int_nxt = ovf_int;
      latch_now   = 1'b0;
      case (state)
         IDLE: begin
            if (gate_rise && armed) begin
               counter_nxt = '0;
               ovf_int_nxt = 1'b0;
               state_nxt   = COUNT;
            end
         end
         COUNT: begin
            if (gate_fall) begin
               state_nxt = LATCH;
            end else if (sig_rise && gate_s2) begin
               if (&counter) begin
                  ovf_int_nxt = 1'b1;
                  if (!SAT_EN) begin
                     counter_nxt = '0;
                  end
               end else begin
                  counter_nxt = counter + CNT_W'(1);
               end
            end
         end
         LATCH: begin
            latch_now = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         freq_cnt_q <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         valid_q <= latch_now;
         if (latch_now) begin
            freq_cnt_q <= counter;
            overflow_q <= ovf_int;
         end
      end
   end

   assign fm.freq_cnt = freq_cnt_q;
   assign fm.valid    = valid_q;
   assign fm.overflow = overflow_q;
   assign fm.busy     = (state == COUNT);

endmodule

// File: tb/tb_gate_freq_meter.sv
// Bench for gate_freq_meter: three instances (16-bit saturating, 4-bit saturating,
// 4-bit wrapping) share one gate/sig_in stimulus; results are checked from queues.
module tb_gate_freq_meter;

   logic clk;
   logic rst;
   logic gate;
   logic sig_in;

   int   errors = 0;
   int   checks = 0;

   typedef struct {
      int cnt;
      int ovf;
   } exp_t;

   typedef struct {
      int pre;
      int n;
      int c16;
      int o16;
      int c4s;
      int o4s;
      int c4w;
      int o4w;
   } vec_t;

   exp_t q16[$];
   exp_t q4s[$];
   exp_t q4w[$];
   vec_t tbl[8];

   gate_freq_meter_if #(.CNT_W(16)) b16 ();
   gate_freq_meter_if #(.CNT_W(4))  b4s ();
   gate_freq_meter_if #(.CNT_W(4))  b4w ();

   assign b16.gate   = gate;
   assign b16.sig_in = sig_in;
   assign b4s.gate   = gate;
   assign b4s.sig_in = sig_in;
   assign b4w.gate   = gate;
   assign b4w.sig_in = sig_in;

   gate_freq_meter #(.CNT_W(16), .SAT_EN(1'b1)) dut16 (.clk_in(clk), .rst(rst), .fm(b16));
   gate_freq_meter #(.CNT_W(4),  .SAT_EN(1'b1)) dut4s (.clk_in(clk), .rst(rst), .fm(b4s));
   gate_freq_meter #(.CNT_W(4),  .SAT_EN(1'b0)) dut4w (.clk_in(clk), .rst(rst), .fm(b4w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   always @(posedge clk) begin : mon16
      exp_t e;
      #1;
      if (b16.valid) begin
         if (q16.size() == 0) chk("w16_unexpected_valid", 1, 0);
         else begin
            e = q16.pop_front();
            chk("w16_freq_cnt", int'(b16.freq_cnt), e.cnt);
            chk("w16_overflow", int'(b16.overflow), e.ovf);
         end
      end
   end

   always @(posedge clk) begin : mon4s
      exp_t e;
      #1;
      if (b4s.valid) begin
         if (q4s.size() == 0) chk("w4s_unexpected_valid", 1, 0);
         else begin
            e = q4s.pop_front();
            chk("w4s_freq_cnt", int'(b4s.freq_cnt), e.cnt);
            chk("w4s_overflow", int'(b4s.overflow), e.ovf);
         end
      end
   end

   always @(posedge clk) begin : mon4w
      exp_t e;
      #1;
      if (b4w.valid) begin
         if (q4w.size() == 0) chk("w4w_unexpected_valid", 1, 0);
         else begin
            e = q4w.pop_front();
            chk("w4w_freq_cnt", int'(b4w.freq_cnt), e.cnt);
            chk("w4w_overflow", int'(b4w.overflow), e.ovf);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse();
      sig_in = 1'b1;
      tick(2);
      sig_in = 1'b0;
      tick(2);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_valid16"},  int'(b16.valid),    0);
      chk({tag, "_busy16"},   int'(b16.busy),     0);
      chk({tag, "_cnt16"},    int'(b16.freq_cnt), 0);
      chk({tag, "_ovf16"},    int'(b16.overflow), 0);
      chk({tag, "_cnt4s"},    int'(b4s.freq_cnt), 0);
      chk({tag, "_ovf4s"},    int'(b4s.overflow), 0);
      chk({tag, "_cnt4w"},    int'(b4w.freq_cnt), 0);
      chk({tag, "_ovf4w"},    int'(b4w.overflow), 0);
   endtask

   task automatic run_window(input vec_t v);
      int used;
      if (v.pre > 0) begin
         repeat (v.pre) pulse();
         tick(4);
      end
      gate = 1'b1;
      tick(10);
      repeat (v.n) pulse();
      used = 10 + 4 * v.n;
      if (used < 50) tick(50 - used);
      else tick(4);
      gate = 1'b0;
      q16.push_back('{v.c16, v.o16});
      q4s.push_back('{v.c4s, v.o4s});
      q4w.push_back('{v.c4w, v.o4w});
      tick(50);
   endtask

   initial begin
      tbl[0] = '{5, 3,   3, 0,  3, 0,  3, 0};
      tbl[1] = '{0, 4,   4, 0,  4, 0,  4, 0};
      tbl[2] = '{0, 9,   9, 0,  9, 0,  9, 0};
      tbl[3] = '{0, 20, 20, 0, 15, 1,  4, 1};
      tbl[4] = '{0, 2,   2, 0,  2, 0,  2, 0};
      tbl[5] = '{0, 0,   0, 0,  0, 0,  0, 0};
      tbl[6] = '{0, 15, 15, 0, 15, 0, 15, 0};
      tbl[7] = '{0, 16, 16, 0, 15, 1,  0, 1};

      rst    = 1'b1;
      gate   = 1'b0;
      sig_in = 1'b0;

      // Reset held 3 cycles with inputs toggling.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         gate   = ~gate;
         sig_in = ~sig_in;
         @(posedge clk);
         #1;
         check_cleared("reset");
      end
      @(negedge clk);
      rst    = 1'b0;
      gate   = 1'b0;
      sig_in = 1'b0;
      tick(20);
      chk("post_reset_busy", int'(b16.busy), 0);

      // Nominal window with exact valid latency from gate pin fall.
      gate = 1'b1;
      tick(10);
      repeat (7) pulse();
      chk("nominal_busy", int'(b16.busy), 1);
      tick(12);
      gate = 1'b0;
      q16.push_back('{7, 0});
      q4s.push_back('{7, 0});
      q4w.push_back('{7, 0});
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk);
         #1;
         chk($sformatf("latency_valid_edge%0d", e), int'(b16.valid), (e == 4) ? 1 : 0);
      end
      @(posedge clk);
      #1;
      chk("valid_one_cycle", int'(b16.valid), 0);
      chk("nominal_hold_cnt", int'(b16.freq_cnt), 7);
      tick(50);

      for (int i = 0; i < 8; i++) run_window(tbl[i]);

      // Reset in the middle of a counting window.
      gate = 1'b1;
      tick(10);
      repeat (3) pulse();
      chk("midrst_busy_before", int'(b16.busy), 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_cleared("midrst");
      tick(20);
      gate = 1'b0;
      tick(50);
      run_window('{0, 6, 6, 0, 6, 0, 6, 0});

      // Reset released while gate is already high.
      rst  = 1'b1;
      gate = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(5);
      repeat (4) pulse();
      tick(5);
      chk("startup_gate_high_busy", int'(b16.busy), 0);
      gate = 1'b0;
      tick(50);
      run_window('{0, 5, 5, 0, 5, 0, 5, 0});

      tick(20);
      chk("pending16", q16.size(), 0);
      chk("pending4s", q4s.size(), 0);
      chk("pending4w", q4w.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
